fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter INDEX_BITS, default 4, log2 of predictor entries (16 by default).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  fetch advance enable; 0 = stall (hazard unit), PC holds.
REQ-006 imem_addr  output  32  instruction memory address; equals current PC.
REQ-007 imem_data  input  32  instruction word; combinational read of imem_addr, same cycle.
REQ-008 pc4_out  output  32  current PC + 4, to the IF/ID register pC4_in.
REQ-009 instruction_out  output  32  imem_data passthrough, to IF/ID instruction_in.
REQ-010 prediction_out  output  1  1 = current fetch predicted taken, to IF/ID prediction_in.
REQ-011 redirect_valid  input  1  EX-stage mispredict/jump correction.
REQ-012 redirect_pc  input  32  corrected next PC.
REQ-013 flush_out  output  1  IF/ID flush request; equals redirect_valid combinationally.
REQ-014 update_valid  input  1  resolved-branch update strobe from EX.
REQ-015 update_pc  input  32  PC of the resolved branch.
REQ-016 update_taken  input  1  resolved direction.
REQ-017 update_target  input  32  resolved taken target.

Function
REQ-018 Index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2]; same split for update_pc.
REQ-019 Per entry state: 2-bit saturating counter, BTB valid bit, tag, 32-bit target.
REQ-020 prediction_out = valid[idx] AND tag match AND counter[idx][1]; combinational from current PC.
REQ-021 Predicted next PC = btb_target[idx] when prediction_out=1, else PC+4.
REQ-022 PC+4 wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-023 PC update priority at each rising edge: rst low > redirect_valid > en > hold.
REQ-024 redirect_valid=1: PC <= {redirect_pc[31:2],2'b00}, regardless of en.
REQ-025 redirect_valid=0, en=1: PC <= predicted next PC; en=0: PC unchanged, outputs stable.
REQ-026 Update, on edge with update_valid=1: counter[uidx] +1 if update_taken else -1, saturating at 2'b11 / 2'b00.
REQ-027 Update with update_taken=1 also writes valid=1, tag, target for uidx; update_taken=0 leaves BTB fields unchanged.
REQ-028 Update applies independent of en and redirect_valid.
REQ-029 Lookup and update to same index in one cycle: lookup uses pre-update state; new state visible next cycle.
REQ-030 Tag mismatch on update overwrites the entry (no associativity); counter still updated from its existing value.
REQ-031 Fetch latency: one PC per cycle; zero-cycle fetch bubble on correctly predicted taken branch.

Reset
REQ-032 On rising edge with rst=0: PC <= RESET_PC, all counters <= 2'b01 (weakly not taken), all valid <= 0; tags/targets don't-care.
REQ-033 Reset overrides concurrent redirect_valid, update_valid, en; no update applied that cycle.
REQ-034 During and after reset: imem_addr=RESET_PC, pc4_out=RESET_PC+4, prediction_out=0.
REQ-035 Reset asserted mid-operation discards all predictor history in one cycle.

Verification
REQ-036 Reset then en=1 for 3 cycles -> imem_addr 0x0, 0x4, 0x8, 0xC; prediction_out=0 throughout.
REQ-037 en=0 at PC=0x8 for 2 cycles -> imem_addr held 0x8, pc4_out 0xC; redirect_valid with redirect_pc=0x103 while en=0 -> next imem_addr 0x100, flush_out=1 that cycle.
REQ-038 Two updates (pc=0x40, taken, target=0x200) -> counter 01->10->11; fetch at 0x40 -> prediction_out=1, next imem_addr 0x200.
REQ-039 From counter 11, three not-taken updates at 0x40 -> 10, 01, 00 (saturates); fetch at 0x40 -> prediction_out=0, next 0x44.
REQ-040 Aliasing: train 0x40 taken, then update 0x80 taken target 0x300 (same index) -> fetch at 0x40 prediction_out=0, fetch at 0x80 prediction_out=1.
REQ-041 PC=0xFFFF_FFFC, en=1 -> pc4_out=0x0, next imem_addr 0x0; rst=0 with update_valid=1 -> all entries reset, no update applied.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction memory, IF/ID outputs, EX redirect and predictor update.
// The master modport is the fetch unit's side of the bundle.
interface fetch_unit_if;
  logic        en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc4_out;
  logic [31:0] instruction_out;
  logic        prediction_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_out;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;

  modport master (
    input  en, imem_data, redirect_valid, redirect_pc,
           update_valid, update_pc, update_taken, update_target,
    output imem_addr, pc4_out, instruction_out, prediction_out, flush_out
  );

  modport slave (
    output en, imem_data, redirect_valid, redirect_pc,
           update_valid, update_pc, update_taken, update_target,
    input  imem_addr, pc4_out, instruction_out, prediction_out, flush_out
  );
endinterface

// File: rtl/fetch_unit.sv
// PC register with a direct-mapped BTB and 2-bit bimodal predictor; one fetch per cycle.
// Lookup is combinational from the current PC; en=0 holds the PC, a redirect wins over en.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          INDEX_BITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 32 - INDEX_BITS - 2;

  logic [31:0]           pc_q, pc_d;
  logic [1:0]            cnt_q    [ENTRIES];
  logic [1:0]            cnt_d    [ENTRIES];
  logic                  valid_q  [ENTRIES];
  logic                  valid_d  [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [TAG_W-1:0]      tag_d    [ENTRIES];
  logic [31:0]           target_q [ENTRIES];
  logic [31:0]           target_d [ENTRIES];

  logic [INDEX_BITS-1:0] idx, uidx;
  logic [TAG_W-1:0]      pc_tag, upd_tag;
  logic [31:0]           pc_plus4, next_pc;
  logic                  hit;
  logic [1:0]            ucnt;

  assign idx      = pc_q[INDEX_BITS+1:2];
  assign pc_tag   = pc_q[31:INDEX_BITS+2];
  assign uidx     = bus.update_pc[INDEX_BITS+1:2];
  assign upd_tag  = bus.update_pc[31:INDEX_BITS+2];
  assign pc_plus4 = pc_q + 32'd4;

  // Lookup reads only the _q state, so a same-cycle update to this index is seen next cycle.
  assign hit     = valid_q[idx] && (tag_q[idx] == pc_tag) && cnt_q[idx][1];
  assign next_pc = hit ? target_q[idx] : pc_plus4;
  assign ucnt    = cnt_q[uidx];

  assign bus.imem_addr       = pc_q;
  assign bus.pc4_out         = pc_plus4;
  assign bus.instruction_out = bus.imem_data;
  assign bus.prediction_out  = hit;
  assign bus.flush_out       = bus.redirect_valid;

  always_comb begin
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;

    if (!rst) begin
      pc_d = RESET_PC;
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_d[i]   = 2'b01;
        valid_d[i] = 1'b0;
      end
    end else begin
      if (bus.redirect_valid) begin
        pc_d = {bus.redirect_pc[31:2], 2'b00};
      end else if (bus.en) begin
        pc_d = next_pc;
      end

      // No associativity: a taken update simply claims the slot for its own tag.
      if (bus.update_valid) begin
        if (bus.update_taken) begin
          cnt_d[uidx]    = (ucnt == 2'b11) ? 2'b11 : ucnt + 2'd1;
          valid_d[uidx]  = 1'b1;
          tag_d[uidx]    = upd_tag;
          target_d[uidx] = bus.update_target;
        end else begin
          cnt_d[uidx]    = (ucnt == 2'b00) ? 2'b00 : ucnt - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    pc_q     <= pc_d;
    cnt_q    <= cnt_d;
    valid_q  <= valid_d;
    tag_q    <= tag_d;
    target_q <= target_d;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, stall/redirect, training, aliasing, wrap.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000), .INDEX_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory model: word is the bitwise inverse of its address.
  assign bus.imem_data = ~bus.imem_addr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.en             = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.update_valid   = 1'b0;
    bus.update_pc      = 32'h0;
    bus.update_taken   = 1'b0;
    bus.update_target  = 32'h0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic goto_pc(input logic [31:0] a);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = a;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    bus.update_valid  = 1'b1;
    bus.update_pc     = pc;
    bus.update_taken  = taken;
    bus.update_target = tgt;
    step();
    bus.update_valid  = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst    = 1'b0;
    bus.en = 1'b1;
    step();
    step();
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr, 32'h0); end
    checks++; if (bus.pc4_out !== 32'h4) begin errors++; $display("FAIL reset_pc4 got=%h exp=%h", bus.pc4_out, 32'h4); end
    checks++; if (bus.prediction_out !== 1'b0) begin errors++; $display("FAIL reset_pred got=%b exp=0", bus.prediction_out); end
    rst    = 1'b1;
    bus.en = 1'b0;
    checks++; if (bus.flush_out !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", bus.flush_out); end
  endtask

  task automatic test_sequential();
    do_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.imem_addr !== 32'(i * 4)) begin errors++; $display("FAIL seq_addr%0d got=%h exp=%h", i, bus.imem_addr, 32'(i * 4)); end
      checks++; if (bus.prediction_out !== 1'b0) begin errors++; $display("FAIL seq_pred%0d got=%b exp=0", i, bus.prediction_out); end
      step();
    end
    bus.en = 1'b0;
    checks++; if (bus.instruction_out !== 32'hFFFF_FFEF) begin errors++; $display("FAIL seq_instr got=%h exp=%h", bus.instruction_out, 32'hFFFF_FFEF); end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    bus.en = 1'b1;
    step();
    step();
    bus.en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr%0d got=%h exp=%h", i, bus.imem_addr, 32'h8); end
      checks++; if (bus.pc4_out !== 32'hC) begin errors++; $display("FAIL stall_pc4%0d got=%h exp=%h", i, bus.pc4_out, 32'hC); end
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h103;
    #1;
    checks++; if (bus.flush_out !== 1'b1) begin errors++; $display("FAIL redir_flush got=%b exp=1", bus.flush_out); end
    step();
    bus.redirect_valid = 1'b0;
    #1;
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got=%h exp=%h", bus.imem_addr, 32'h100); end
    checks++; if (bus.flush_out !== 1'b0) begin errors++; $display("FAIL redir_flush_clr got=%b exp=0", bus.flush_out); end
    bus.en             = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h20;
    step();
    idle();
    checks++; if (bus.imem_addr !== 32'h20) begin errors++; $display("FAIL redir_over_en got=%h exp=%h", bus.imem_addr, 32'h20); end
  endtask

  task automatic test_train_taken();
    do_reset();
    goto_pc(32'h40);
    bus.update_valid  = 1'b1;
    bus.update_pc     = 32'h40;
    bus.update_taken  = 1'b1;
    bus.update_target = 32'h200;
    #1;
    checks++; if (bus.prediction_out !== 1'b0) begin errors++; $display("FAIL train_pre_update got=%b exp=0", bus.prediction_out); end
    step();
    bus.update_valid = 1'b0;
    #1;
    checks++; if (bus.prediction_out !== 1'b1) begin errors++; $display("FAIL train_cnt10 got=%b exp=1", bus.prediction_out); end
    train(32'h40, 1'b1, 32'h200);
    checks++; if (bus.prediction_out !== 1'b1) begin errors++; $display("FAIL train_cnt11 got=%b exp=1", bus.prediction_out); end
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    checks++; if (bus.imem_addr !== 32'h200) begin errors++; $display("FAIL train_target got=%h exp=%h", bus.imem_addr, 32'h200); end
  endtask

  task automatic test_saturate_down();
    logic exp_pred [4];
    exp_pred[0] = 1'b1;
    exp_pred[1] = 1'b0;
    exp_pred[2] = 1'b0;
    exp_pred[3] = 1'b0;
    do_reset();
    train(32'h40, 1'b1, 32'h200);
    train(32'h40, 1'b1, 32'h200);
    goto_pc(32'h40);
    for (int i = 0; i < 3; i++) begin
      train(32'h40, 1'b0, 32'h0);
      checks++; if (bus.prediction_out !== exp_pred[i]) begin errors++; $display("FAIL sat_nt%0d got=%b exp=%b", i, bus.prediction_out, exp_pred[i]); end
    end
    // Counter at 00 must step to 01 (still not taken), not wrap.
    train(32'h40, 1'b1, 32'h200);
    checks++; if (bus.prediction_out !== exp_pred[3]) begin errors++; $display("FAIL sat_floor got=%b exp=%b", bus.prediction_out, exp_pred[3]); end
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    checks++; if (bus.imem_addr !== 32'h44) begin errors++; $display("FAIL sat_next got=%h exp=%h", bus.imem_addr, 32'h44); end
  endtask

  task automatic test_alias();
    do_reset();
    train(32'h40, 1'b1, 32'h200);
    train(32'h40, 1'b1, 32'h200);
    train(32'h80, 1'b1, 32'h300);
    goto_pc(32'h40);
    checks++; if (bus.prediction_out !== 1'b0) begin errors++; $display("FAIL alias_40_pred got=%b exp=0", bus.prediction_out); end
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    checks++; if (bus.imem_addr !== 32'h44) begin errors++; $display("FAIL alias_40_next got=%h exp=%h", bus.imem_addr, 32'h44); end
    goto_pc(32'h80);
    checks++; if (bus.prediction_out !== 1'b1) begin errors++; $display("FAIL alias_80_pred got=%b exp=1", bus.prediction_out); end
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    checks++; if (bus.imem_addr !== 32'h300) begin errors++; $display("FAIL alias_80_next got=%h exp=%h", bus.imem_addr, 32'h300); end
  endtask

  task automatic test_wrap();
    do_reset();
    goto_pc(32'hFFFF_FFFC);
    checks++; if (bus.pc4_out !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got=%h exp=%h", bus.pc4_out, 32'h0); end
    checks++; if (bus.prediction_out !== 1'b0) begin errors++; $display("FAIL wrap_pred got=%b exp=0", bus.prediction_out); end
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got=%h exp=%h", bus.imem_addr, 32'h0); end
  endtask

  task automatic test_reset_with_update();
    do_reset();
    train(32'h40, 1'b1, 32'h200);
    goto_pc(32'h40);
    checks++; if (bus.prediction_out !== 1'b1) begin errors++; $display("FAIL rstupd_pre got=%b exp=1", bus.prediction_out); end
    rst                = 1'b0;
    bus.en             = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    bus.update_valid   = 1'b1;
    bus.update_pc      = 32'h40;
    bus.update_taken   = 1'b1;
    bus.update_target  = 32'h500;
    step();
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rstupd_addr got=%h exp=%h", bus.imem_addr, 32'h0); end
    rst = 1'b1;
    idle();
    goto_pc(32'h40);
    checks++; if (bus.prediction_out !== 1'b0) begin errors++; $display("FAIL rstupd_valid got=%b exp=0", bus.prediction_out); end
    // Counters restart at 01: not-taken then taken lands back on 01.
    train(32'h40, 1'b0, 32'h0);
    train(32'h40, 1'b1, 32'h600);
    checks++; if (bus.prediction_out !== 1'b0) begin errors++; $display("FAIL rstupd_cnt got=%b exp=0", bus.prediction_out); end
    train(32'h40, 1'b1, 32'h600);
    checks++; if (bus.prediction_out !== 1'b1) begin errors++; $display("FAIL rstupd_retrain got=%b exp=1", bus.prediction_out); end
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    checks++; if (bus.imem_addr !== 32'h600) begin errors++; $display("FAIL rstupd_target got=%h exp=%h", bus.imem_addr, 32'h600); end
  endtask

  initial begin
    idle();
    rst = 1'b0;
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_train_taken();
    test_saturate_down();
    test_alias();
    test_wrap();
    test_reset_with_update();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
